demux_1to4_buf: RTL and testbench
=================================

# demux_1to4_buf

Buffered 1-to-4 demultiplexer: accepts one data word per handshake on a single input channel and routes it to one of four output channels chosen by `select_i`. Each output channel owns a one-entry holding register with its own valid/ready handshake, so a stalled destination never corrupts words bound for the others. It sits on the write/result side of the datapath, steering a single producer's results to one of four consumers.

## Interface
Parameters:
- `size`, default 32: data width in bits.

Ports:
- `clk_i`  input  1  clock; all state updates on rising edge.
- `rst_i`  input  1  reset, synchronous, active-high.
- `data_i`  input  size  input word.
- `select_i`  input  2  destination channel (0..3) for `data_i`.
- `valid_i`  input  1  input word and select are valid.
- `ready_o`  output  1  block accepts the input word this cycle.
- `data0_o`..`data3_o`  output  size  channel 0..3 held word.
- `valid_o`  output  4  bit n: channel n holds a word.
- `ready_i`  input  4  bit n: consumer n takes the channel n word this cycle.
- `accept_cnt_o`  output  8  count of accepted input words, wraps 255 -> 0.

## Operation
- Input transfer occurs on an edge where `valid_i && ready_o`.
- Output transfer on channel n occurs on an edge where `valid_o[n] && ready_i[n]`.
- `ready_o` is combinational: `!valid_o[select_i] || ready_i[select_i]`. It depends only on the selected channel; the state of other channels is irrelevant.
- Per channel n, one state bit `valid_o[n]`, two states:
  - EMPTY (`valid_o[n]=0`): input transfer with `select_i==n` -> load `data_i` into `datan_o`, go FULL.
  - FULL (`valid_o[n]=1`):
    - Output transfer with no input transfer to n -> go EMPTY. `datan_o` keeps its old value.
    - Output transfer with input transfer to n in the same cycle -> load the new word, stay FULL.
    - Otherwise hold the word and stay FULL.
- `datan_o` changes only on a load; stable while FULL and not transferring.
- `select_i` and `data_i` are ignored when `valid_i=0`.
- Only one channel can load per cycle. Any number of channels can drain in the same cycle.
- `accept_cnt_o` increments by 1 on each input transfer, modulo 256.
- `ready_i[n]` while channel n is EMPTY has no effect.

## Timing
- Reset values: `valid_o=4'b0000`, `data0_o`..`data3_o` = 0, `accept_cnt_o=0`. During reset `ready_o` follows its equation with `valid_o=0`, so it reads 1. No transfer is taken while `rst_i=1`.
- Reset has priority over all transfers. Asserting reset mid-operation discards all buffered words and the count on that edge.
- Latency: a word accepted at edge k is visible on `datan_o` with `valid_o[n]=1` after edge k, i.e. 1 cycle.
- Throughput: 1 word per cycle into any channel. On a single channel this holds while its consumer keeps `ready_i[n]=1`, using the same-cycle drain+fill path.
- Backpressure: FULL channel n with `ready_i[n]=0` and `select_i==n` gives `ready_o=0`. The producer must hold `data_i`/`select_i` stable until accepted.
- No combinational path from `data_i` to any output. The only combinational paths are `select_i`/`ready_i` -> `ready_o`.

## Test plan
- Reset: drive `rst_i=1` for 2 cycles with `valid_i=1` -> `valid_o=0`, all data 0, `accept_cnt_o=0`. After release, first word accepted and count=1.
- Routing: with all `ready_i=0`, send 0xA0,0xA1,0xA2,0xA3 to selects 0,1,2,3 on consecutive cycles -> each `datan_o` holds 0xAn, `valid_o=4'b1111`, count=4, `ready_o=1` throughout.
- Backpressure: channel 2 FULL with 0x55 and `ready_i[2]=0`; present 0x66 to select 2 -> `ready_o=0`, `data2_o` stays 0x55. Raise `ready_i[2]` -> on that same edge 0x55 drains and 0x66 loads, `valid_o[2]` stays 1.
- Isolation: channel 1 stalled FULL; stream 10 words to channel 3 with `ready_i[3]=1` -> all 10 accepted back-to-back, channel 1 word unchanged.
- Wrap and reset mid-stream: accept 257 words -> `accept_cnt_o=1`. Assert `rst_i` with channels FULL -> next cycle `valid_o=0`, count=0.

Source files
------------

// File: rtl/demux_1to4_buf.sv
// Buffered 1-to-4 demux: one input word per handshake steered by select_i into one of four one-entry channel registers.
// Latency: 1 cycle from input acceptance to valid_o[n]/datan_o; one word per cycle sustained.
// Backpressure: ready_o drops only when the selected channel is full and its consumer is not draining it this cycle.
module demux_1to4_buf #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [size-1:0] data_i,
    input  logic [1:0]      select_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [size-1:0] data0_o,
    output logic [size-1:0] data1_o,
    output logic [size-1:0] data2_o,
    output logic [size-1:0] data3_o,
    output logic [3:0]      valid_o,
    input  logic [3:0]      ready_i,
    output logic [7:0]      accept_cnt_o
);

    logic [3:0]      valid_q, valid_d;
    logic [size-1:0] data_q [4];
    logic [size-1:0] data_d [4];
    logic [7:0]      cnt_q, cnt_d;
    logic            in_xfer;
    logic [3:0]      load;

    // Accept when the selected slot is empty or is being drained on this same edge.
    always_comb begin
        ready_o = !valid_q[select_i] || ready_i[select_i];
        in_xfer = valid_i && ready_o;
    end

    // Per-channel next state: a load wins over a drain so drain+fill keeps the slot full.
    always_comb begin
        valid_d = valid_q;
        cnt_d   = cnt_q;
        load    = '0;
        for (int n = 0; n < 4; n++) begin
            data_d[n] = data_q[n];
            load[n]   = in_xfer && (select_i == 2'(n));
            if (load[n]) begin
                valid_d[n] = 1'b1;
                data_d[n]  = data_i;
            end else if (ready_i[n]) begin
                // Drained (or already empty): the held word stays on the output untouched.
                valid_d[n] = 1'b0;
            end
        end
        if (in_xfer) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // State registers; reset discards buffered words and the acceptance count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int n = 0; n < 4; n++) begin
                data_q[n] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int n = 0; n < 4; n++) begin
                data_q[n] <= data_d[n];
            end
        end
    end

    assign data0_o      = data_q[0];
    assign data1_o      = data_q[1];
    assign data2_o      = data_q[2];
    assign data3_o      = data_q[3];
    assign valid_o      = valid_q;
    assign accept_cnt_o = cnt_q;

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Bench for demux_1to4_buf: directed scenarios plus random traffic against a per-channel slot model.
// Outputs are compared against the model on every falling edge; directed phases add literal checks.
// Reset is exercised at start, mid-stream and randomly during the random phase.
module tb_demux_1to4_buf;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] data_i;
    logic [1:0]  select_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data0_o, data1_o, data2_o, data3_o;
    logic [3:0]  valid_o;
    logic [3:0]  ready_i;
    logic [7:0]  accept_cnt_o;

    int checks   = 0;
    int failures = 0;

    // Model: each channel is an optional word; the output shows the last word loaded.
    bit          m_full [4];
    logic [31:0] m_word [4];
    int          m_cnt;
    bit          model_ok = 0;
    bit          tb_done  = 0;

    demux_1to4_buf #(.size(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .select_i     (select_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data0_o      (data0_o),
        .data1_o      (data1_o),
        .data2_o      (data2_o),
        .data3_o      (data3_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .accept_cnt_o (accept_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model update on each rising edge, from the inputs present before it.
    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < 4; n++) begin
                m_full[n] = 0;
                m_word[n] = 32'd0;
            end
            m_cnt    = 0;
            model_ok = 1;
        end else if (model_ok) begin
            bit accepted;
            accepted = valid_i && (!m_full[select_i] || ready_i[select_i]);
            for (int n = 0; n < 4; n++) begin
                if (m_full[n] && ready_i[n]) m_full[n] = 0;
            end
            if (accepted) begin
                m_full[select_i] = 1;
                m_word[select_i] = data_i;
                m_cnt = (m_cnt + 1) % 256;
            end
        end
    end

    // Compare process: every falling edge once the model is initialised.
    always @(negedge clk_i) begin
        if (model_ok && !tb_done) begin
            logic [31:0] dd [4];
            logic [3:0]  ev;
            dd[0] = data0_o; dd[1] = data1_o; dd[2] = data2_o; dd[3] = data3_o;
            ev = {3'b000, m_full[0]} | {2'b00, m_full[1], 1'b0} |
                 {1'b0, m_full[2], 2'b00} | {m_full[3], 3'b000};
            chk("cyc_valid_o", {28'd0, valid_o}, {28'd0, ev});
            for (int n = 0; n < 4; n++) begin
                chk($sformatf("cyc_data%0d_o", n), dd[n], m_word[n]);
            end
            chk("cyc_accept_cnt", {24'd0, accept_cnt_o}, 32'(m_cnt));
            chk("cyc_ready_o", {31'd0, ready_o},
                {31'd0, (!m_full[select_i] || ready_i[select_i])});
        end
    end

    task automatic set_in(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
        valid_i  = v;
        select_i = s;
        data_i   = d;
        ready_i  = r;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
        set_in(v, s, d, r);
        tick();
    endtask

    initial begin
        rst_i = 1'b1;
        set_in(1'b1, 2'd0, 32'hDEAD, 4'h0);

        // Reset held with valid_i=1: nothing is taken.
        tick();
        tick();
        chk("rst_valid_o", {28'd0, valid_o}, 32'h0);
        chk("rst_data0", data0_o, 32'h0);
        chk("rst_data3", data3_o, 32'h0);
        chk("rst_cnt", {24'd0, accept_cnt_o}, 32'h0);
        chk("rst_ready_o", {31'd0, ready_o}, 32'h1);

        rst_i = 1'b0;
        step(1'b1, 2'd1, 32'h11, 4'h0);
        chk("first_cnt", {24'd0, accept_cnt_o}, 32'd1);
        chk("first_valid", {28'd0, valid_o}, 32'h2);
        chk("first_data1", data1_o, 32'h11);

        // Routing from a clean state, consumers all stalled.
        rst_i = 1'b1;
        step(1'b0, 2'd0, 32'h0, 4'h0);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 2'(i), 32'hA0 + 32'(i), 4'h0);
            #1;
            chk("route_ready_o", {31'd0, ready_o}, 32'h1);
            tick();
        end
        chk("route_valid", {28'd0, valid_o}, 32'hF);
        chk("route_data0", data0_o, 32'hA0);
        chk("route_data1", data1_o, 32'hA1);
        chk("route_data2", data2_o, 32'hA2);
        chk("route_data3", data3_o, 32'hA3);
        chk("route_cnt", {24'd0, accept_cnt_o}, 32'd4);

        // Backpressure on channel 2.
        step(1'b0, 2'd0, 32'h0, 4'hF);
        step(1'b1, 2'd2, 32'h55, 4'h0);
        set_in(1'b1, 2'd2, 32'h66, 4'h0);
        #1;
        chk("bp_ready_low", {31'd0, ready_o}, 32'h0);
        tick();
        chk("bp_data2_held", data2_o, 32'h55);
        chk("bp_cnt_held", {24'd0, accept_cnt_o}, 32'd5);
        set_in(1'b1, 2'd2, 32'h66, 4'b0100);
        #1;
        chk("bp_ready_high", {31'd0, ready_o}, 32'h1);
        tick();
        chk("bp_data2_new", data2_o, 32'h66);
        chk("bp_valid2", {31'd0, valid_o[2]}, 32'h1);
        chk("bp_cnt", {24'd0, accept_cnt_o}, 32'd6);

        // Isolation: channel 1 stalled while channel 3 streams.
        step(1'b1, 2'd1, 32'h77, 4'h0);
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 2'd3, 32'h300 + 32'(i), 4'b1000);
            #1;
            chk("iso_ready_o", {31'd0, ready_o}, 32'h1);
            tick();
        end
        chk("iso_cnt", {24'd0, accept_cnt_o}, 32'd17);
        chk("iso_data1", data1_o, 32'h77);
        chk("iso_data3", data3_o, 32'h309);
        chk("iso_valid", {28'd0, valid_o}, 32'hE);

        // Random traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            rst_i = ($urandom_range(0, 59) == 0);
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 $urandom, 4'($urandom));
        end
        rst_i = 1'b0;

        // Counter wrap: 257 accepted words with every consumer draining.
        rst_i = 1'b1;
        step(1'b0, 2'd0, 32'h0, 4'h0);
        rst_i = 1'b0;
        for (int i = 0; i < 257; i++) begin
            step(1'b1, 2'($urandom_range(0, 3)), $urandom, 4'hF);
        end
        chk("wrap_cnt", {24'd0, accept_cnt_o}, 32'd1);

        // Mid-stream reset with channels full.
        step(1'b1, 2'd0, 32'hC0, 4'h0);
        step(1'b1, 2'd1, 32'hC1, 4'h0);
        chk("pre_rst_valid", {30'd0, valid_o[1:0]}, 32'h3);
        rst_i = 1'b1;
        step(1'b1, 2'd2, 32'hC2, 4'h0);
        chk("mid_rst_valid", {28'd0, valid_o}, 32'h0);
        chk("mid_rst_cnt", {24'd0, accept_cnt_o}, 32'h0);
        chk("mid_rst_data1", data1_o, 32'h0);
        rst_i = 1'b0;
        step(1'b0, 2'd0, 32'h0, 4'h0);

        tb_done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
